ram_bus_arbiter: RTL and testbench
==================================

# ram_bus_arbiter

Two-master arbiter and sequencer for the shared single-port program/data RAM. It serialises accesses from the program loader/debug port (master 0) and the CPU core (master 1) onto one RAM port. It enforces the RAM's fixed read latency and returns a one-cycle acknowledge with read data to the winning master. It sits between both masters and the RAM, so the CPU no longer drives the RAM directly.

## Interface
- `AW`, 8: address width.
- `DW`, 8: data width.
- `RD_LAT`, 1: RAM read latency in clocks, from address valid to `ram_dout` valid. Legal range 1..4.
- `clk_qzt` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `m0_req`, `m1_req` in 1: access request; held until the matching ack.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read; held with req.
- `m0_addr`, `m1_addr` in AW: access address; held with req.
- `m0_wdata`, `m1_wdata` in DW: write data; held with req.
- `m0_ack`, `m1_ack` out 1: single-cycle completion pulse.
- `rdata` out DW: read data, valid in the ack cycle, held until the next read completes.
- `gnt` out 2: one-hot current owner; 00 when idle.
- `busy` out 1: high in any state other than IDLE.
- `ram_addr` out AW: RAM address.
- `ram_din` out DW: RAM write data.
- `ram_we` out 1: RAM write strobe.
- `ram_dout` in DW: RAM read data.

## Operation
- Reset values: state IDLE; `ram_addr`, `ram_din`, `rdata` = 0; `ram_we`, `m0_ack`, `m1_ack`, `busy` = 0; `gnt` = 00; last-owner = master 1.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a winner, latch its `we`/`addr`/`wdata`, drive `ram_addr`/`ram_din`, and set `gnt`.
  - Write: set `ram_we`=1.
  - Load wait counter = `RD_LAT`-1, then go to ACCESS.
- ACCESS, write: `ram_we`=1 for exactly this one cycle, then clear it and go to DONE.
- ACCESS, read: hold the address, decrement the counter each cycle, and sample `ram_dout` into `rdata` when the counter is 0. Then go to DONE.
- DONE: pulse the owner's ack for one cycle, update last-owner, clear `gnt`, and return to IDLE.
- Fixed priority (default): master 0 wins a simultaneous request.
- Request/operand rules:
  - A requester drops req no later than the cycle after its ack. A req still high in IDLE is treated as a new access.
  - Operands are latched in IDLE, so changes after grant have no effect.
  - A req dropped before ack is ignored; the access completes and the ack is still pulsed.
- Addresses wrap naturally. No range checks are performed.

## Timing
- Request seen high at cycle N in IDLE → RAM address valid at N+1.
- Write: `ram_we` high during N+1 only; ack at N+2.
- Read: address held N+1..N+`RD_LAT`; ack and `rdata` valid at N+`RD_LAT`+1. With `RD_LAT`=1, ack is at N+2.
- Back-to-back throughput with req held: one access per `RD_LAT`+2 cycles.
- The losing master waits until the current access completes. With fixed priority, a continuously requesting master 0 can starve master 1.
- Async reset mid-access: `ram_we` drops immediately, no ack is issued, and the aborted access is never retried.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, the master that was not last-owner wins. Because last-owner resets to 1, master 0 wins the first contest. A lone requester always wins.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, master 0 always wins. The last-owner register still exists but does not affect selection.

## Test plan
- Reset values: assert `reset_n`=0 mid-write with `ram_we`=1 → `ram_we`, `gnt`, and both acks go to 0 immediately; state is IDLE after release; no ack follows.
- Single write: m1 writes 0x5A to 0x10 with `RD_LAT`=1 → `ram_we`=1 for one cycle at N+1 with `ram_addr`=0x10 and `ram_din`=0x5A; `m1_ack` at N+2; `gnt`=10 during N+1..N+2.
- Single read: RAM holds 0xC3 at 0x00; m0 reads with `RD_LAT`=3 → `m0_ack` at N+4 with `rdata`=0xC3; `ram_we` stays 0 throughout.
- Simultaneous requests, fixed priority: both masters request every cycle for 4 accesses → all 4 acks go to m0; m1 gets no ack.
- Simultaneous requests with `ARB_ROUND_ROBIN_EN`: same stimulus → ack order is m0, m1, m0, m1; each access takes 3 cycles with `RD_LAT`=1.
- Operand latching: m1 changes `m1_addr` from 0x20 to 0x30 one cycle after grant → RAM sees 0x20 only; ack still issued once.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared single-port program/data RAM.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed master-0 priority.
module ram_bus_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk_qzt,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic [DW-1:0] rdata,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

    state_t        state_r, state_s;
    logic [1:0]    cnt_r, cnt_s;
    logic          we_r, we_s;
    logic          owner_r, owner_s;
    logic          last_owner_r, last_owner_s;
    logic [AW-1:0] ram_addr_r, ram_addr_s;
    logic [DW-1:0] ram_din_r, ram_din_s;
    logic          ram_we_r, ram_we_s;
    logic [DW-1:0] rdata_r, rdata_s;
    logic [1:0]    gnt_r, gnt_s;
    logic          m0_ack_r, m0_ack_s;
    logic          m1_ack_r, m1_ack_s;
    logic          busy_r, busy_s;
    logic          prefer_m0_s;
    logic          pick_m0_s;

`ifdef ARB_ROUND_ROBIN_EN
    // m0 is preferred in a contest only when m1 owned the previous access
    assign prefer_m0_s = last_owner_r;
`else
    // last owner is tracked, but fixed priority always prefers m0
    assign prefer_m0_s = last_owner_r | 1'b1;
`endif
    assign pick_m0_s = m0_req & (~m1_req | prefer_m0_s);

    // Next-state and next-output logic for the access sequencer
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        we_s         = we_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        ram_addr_s   = ram_addr_r;
        ram_din_s    = ram_din_r;
        ram_we_s     = ram_we_r;
        rdata_s      = rdata_r;
        gnt_s        = gnt_r;
        m0_ack_s     = 1'b0;
        m1_ack_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_s    = ~pick_m0_s;
                    we_s       = pick_m0_s ? m0_we    : m1_we;
                    ram_addr_s = pick_m0_s ? m0_addr  : m1_addr;
                    ram_din_s  = pick_m0_s ? m0_wdata : m1_wdata;
                    ram_we_s   = pick_m0_s ? m0_we    : m1_we;
                    gnt_s      = pick_m0_s ? 2'b01    : 2'b10;
                    cnt_s      = CNT_LOAD;
                    state_s    = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // ack is raised on entry to DONE so it is visible during DONE
                if (we_r) begin
                    ram_we_s = 1'b0;
                    m0_ack_s = ~owner_r;
                    m1_ack_s = owner_r;
                    state_s  = DONE;
                end else if (cnt_r == 2'd0) begin
                    rdata_s  = ram_dout;
                    m0_ack_s = ~owner_r;
                    m1_ack_s = owner_r;
                    state_s  = DONE;
                end else begin
                    cnt_s = cnt_r - 2'd1;
                end
            end
            DONE: begin
                last_owner_s = owner_r;
                gnt_s        = 2'b00;
                state_s      = IDLE;
            end
            default: begin
                ram_we_s = 1'b0;
                gnt_s    = 2'b00;
                state_s  = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            we_r         <= 1'b0;
            owner_r      <= 1'b0;
            last_owner_r <= 1'b1;
            ram_addr_r   <= '0;
            ram_din_r    <= '0;
            ram_we_r     <= 1'b0;
            rdata_r      <= '0;
            gnt_r        <= 2'b00;
            m0_ack_r     <= 1'b0;
            m1_ack_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            we_r         <= we_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            ram_addr_r   <= ram_addr_s;
            ram_din_r    <= ram_din_s;
            ram_we_r     <= ram_we_s;
            rdata_r      <= rdata_s;
            gnt_r        <= gnt_s;
            m0_ack_r     <= m0_ack_s;
            m1_ack_r     <= m1_ack_s;
            busy_r       <= busy_s;
        end
    end

    assign m0_ack   = m0_ack_r;
    assign m1_ack   = m1_ack_r;
    assign rdata    = rdata_r;
    assign gnt      = gnt_r;
    assign busy     = busy_r;
    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;
    assign ram_we   = ram_we_r;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: instance a uses RD_LAT=1, instance b uses RD_LAT=3.
module tb_ram_bus_arbiter;

    logic       clk_qzt = 1'b0;
    logic       reset_n = 1'b1;
    int         checks = 0;
    int         failures = 0;

    logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0] m0_addr = 8'h00, m0_wdata = 8'h00, m1_addr = 8'h00, m1_wdata = 8'h00;
    logic       m0_ack, m1_ack, busy, ram_we;
    logic [7:0] rdata, ram_addr, ram_din, ram_dout;
    logic [1:0] gnt;
    logic [7:0] mem_a [256];

    logic       b_m0_req = 1'b0, b_m0_we = 1'b0;
    logic [7:0] b_m0_addr = 8'h00, b_m0_wdata = 8'h00;
    logic       b_m0_ack, b_m1_ack, b_busy, b_ram_we;
    logic [7:0] b_rdata, b_ram_addr, b_ram_din, b_ram_dout;
    logic [1:0] b_gnt;
    logic [7:0] mem_b [256];
    logic [7:0] b_pipe1, b_pipe2;

    always #5 clk_qzt = ~clk_qzt;

    ram_bus_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) dut_a (
        .clk_qzt(clk_qzt), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .rdata(rdata), .gnt(gnt), .busy(busy),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    ram_bus_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) dut_b (
        .clk_qzt(clk_qzt), .reset_n(reset_n),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(8'h00), .m1_wdata(8'h00),
        .m0_ack(b_m0_ack), .m1_ack(b_m1_ack), .rdata(b_rdata), .gnt(b_gnt), .busy(b_busy),
        .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_we(b_ram_we), .ram_dout(b_ram_dout)
    );

    // RAM models: a has data in the address cycle, b after two extra pipeline stages
    always @(posedge clk_qzt) begin
        if (ram_we) mem_a[ram_addr] <= ram_din;
        if (b_ram_we) mem_b[b_ram_addr] <= b_ram_din;
        b_pipe1 <= b_ram_addr;
        b_pipe2 <= b_pipe1;
    end
    assign ram_dout   = mem_a[ram_addr];
    assign b_ram_dout = mem_b[b_pipe2];

    task automatic test_reset();
        logic bad;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({m0_ack, m1_ack, busy, ram_we, gnt, ram_addr, ram_din, rdata} !== 30'd0) begin
            failures++;
            $display("FAIL reset_values: got %h expected 0",
                     {m0_ack, m1_ack, busy, ram_we, gnt, ram_addr, ram_din, rdata});
        end
        @(negedge clk_qzt); reset_n = 1'b1;
        @(posedge clk_qzt); #1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h44; m1_wdata = 8'h99;
        @(negedge clk_qzt);
        @(negedge clk_qzt);
        checks++;
        if (ram_we !== 1'b1) begin
            failures++; $display("FAIL reset_pre_we: got %b expected 1", ram_we);
        end
        #1 reset_n = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
        #1;
        checks++;
        if ({ram_we, gnt, m0_ack, m1_ack} !== 5'd0) begin
            failures++;
            $display("FAIL reset_mid_write: got %b expected 00000", {ram_we, gnt, m0_ack, m1_ack});
        end
        @(negedge clk_qzt); reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_qzt);
            if (m0_ack || m1_ack || busy || ram_we) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++; $display("FAIL reset_no_ack_after: got activity=%b expected 0", bad);
        end
        checks++;
        if (mem_a[8'h44] === 8'h99) begin
            failures++; $display("FAIL reset_no_retry: got mem=%h expected unwritten", mem_a[8'h44]);
        end
    endtask

    task automatic test_single_write();
        @(posedge clk_qzt); #1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h10; m1_wdata = 8'h5A;
        @(negedge clk_qzt);
        @(negedge clk_qzt);
        checks++;
        if ({ram_we, ram_addr, ram_din, gnt, m1_ack} !== {1'b1, 8'h10, 8'h5A, 2'b10, 1'b0}) begin
            failures++;
            $display("FAIL write_n1: got we=%b addr=%h din=%h gnt=%b ack=%b expected 1 10 5a 10 0",
                     ram_we, ram_addr, ram_din, gnt, m1_ack);
        end
        @(negedge clk_qzt);
        checks++;
        if ({ram_we, gnt, m1_ack, m0_ack} !== {1'b0, 2'b10, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL write_n2: got we=%b gnt=%b m1_ack=%b m0_ack=%b expected 0 10 1 0",
                     ram_we, gnt, m1_ack, m0_ack);
        end
        @(posedge clk_qzt); #1;
        m1_req = 1'b0; m1_we = 1'b0;
        @(negedge clk_qzt);
        checks++;
        if ({m1_ack, gnt, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL write_n3: got ack=%b gnt=%b busy=%b expected 0 00 0", m1_ack, gnt, busy);
        end
        checks++;
        if (mem_a[8'h10] !== 8'h5A) begin
            failures++; $display("FAIL write_mem: got %h expected 5a", mem_a[8'h10]);
        end
    endtask

    task automatic test_single_read();
        @(posedge clk_qzt); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h10;
        @(negedge clk_qzt);
        @(negedge clk_qzt);
        checks++;
        if ({ram_we, ram_addr, gnt, m0_ack} !== {1'b0, 8'h10, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL read1_n1: got we=%b addr=%h gnt=%b ack=%b expected 0 10 01 0",
                     ram_we, ram_addr, gnt, m0_ack);
        end
        @(negedge clk_qzt);
        checks++;
        if ({m0_ack, m1_ack, rdata} !== {1'b1, 1'b0, 8'h5A}) begin
            failures++;
            $display("FAIL read1_n2: got m0_ack=%b m1_ack=%b rdata=%h expected 1 0 5a",
                     m0_ack, m1_ack, rdata);
        end
        @(posedge clk_qzt); #1;
        m0_req = 1'b0;
        @(negedge clk_qzt);
    endtask

    task automatic test_operand_latch();
        int acks;
        logic saw30;
        acks = 0; saw30 = 1'b0;
        @(posedge clk_qzt); #1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h20; m1_wdata = 8'h11;
        @(posedge clk_qzt); #1;
        m1_addr = 8'h30; m1_wdata = 8'hEE; m1_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_qzt);
            if (m1_ack) acks++;
            if (ram_addr === 8'h30) saw30 = 1'b1;
        end
        checks++;
        if (acks !== 1) begin
            failures++; $display("FAIL latch_ack_count: got %0d expected 1", acks);
        end
        checks++;
        if (saw30 !== 1'b0 || ram_addr !== 8'h20) begin
            failures++; $display("FAIL latch_addr: got addr=%h saw30=%b expected 20 0", ram_addr, saw30);
        end
        checks++;
        if (mem_a[8'h20] !== 8'h11) begin
            failures++; $display("FAIL latch_mem: got %h expected 11", mem_a[8'h20]);
        end
        checks++;
        if (rdata !== 8'h5A) begin
            failures++; $display("FAIL rdata_hold: got %h expected 5a", rdata);
        end
        m1_we = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_ack;
        @(negedge clk_qzt); reset_n = 1'b0;
        @(negedge clk_qzt); reset_n = 1'b1;
        @(posedge clk_qzt); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h80; m0_wdata = 8'hA0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h90; m1_wdata = 8'hB0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_qzt);
            exp_ack = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            if (i == 2 || i == 8) exp_ack = 2'b01;
            if (i == 5 || i == 11) exp_ack = 2'b10;
`else
            if (i == 2 || i == 5 || i == 8 || i == 11) exp_ack = 2'b01;
`endif
            checks++;
            if ({m1_ack, m0_ack} !== exp_ack) begin
                failures++;
                $display("FAIL contest_cycle%0d: got {m1_ack,m0_ack}=%b expected %b",
                         i, {m1_ack, m0_ack}, exp_ack);
            end
        end
        @(posedge clk_qzt); #1;
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        @(negedge clk_qzt);
        @(negedge clk_qzt);
    endtask

    task automatic b_write(input logic [7:0] addr, input logic [7:0] data);
        logic seen;
        seen = 1'b0;
        @(posedge clk_qzt); #1;
        b_m0_req = 1'b1; b_m0_we = 1'b1; b_m0_addr = addr; b_m0_wdata = data;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_qzt);
            if (b_m0_ack) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL b_write_timeout: got no ack expected ack within 10 cycles");
        end
        @(posedge clk_qzt); #1;
        b_m0_req = 1'b0; b_m0_we = 1'b0;
        @(negedge clk_qzt);
    endtask

    task automatic test_read_latency3();
        logic bad;
        b_write(8'h00, 8'hC3);
        b_write(8'h01, 8'h5E);
        @(posedge clk_qzt); #1;
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 8'h00;
        @(negedge clk_qzt);
        bad = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_qzt);
            if (b_ram_we !== 1'b0 || b_m0_ack !== 1'b0 || b_ram_addr !== 8'h00 ||
                b_gnt !== 2'b01 || b_busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++; $display("FAIL read3_hold: got bad=%b expected 0", bad);
        end
        @(negedge clk_qzt);
        checks++;
        if ({b_m0_ack, b_m1_ack, b_rdata, b_ram_we} !== {1'b1, 1'b0, 8'hC3, 1'b0}) begin
            failures++;
            $display("FAIL read3_ack: got ack=%b m1_ack=%b rdata=%h we=%b expected 1 0 c3 0",
                     b_m0_ack, b_m1_ack, b_rdata, b_ram_we);
        end
        @(posedge clk_qzt); #1;
        b_m0_req = 1'b0;
        @(negedge clk_qzt);
        checks++;
        if ({b_m0_ack, b_busy, b_rdata, b_ram_din} !== {1'b0, 1'b0, 8'hC3, 8'h5E}) begin
            failures++;
            $display("FAIL read3_after: got ack=%b busy=%b rdata=%h din=%h expected 0 0 c3 5e",
                     b_m0_ack, b_busy, b_rdata, b_ram_din);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_operand_latch();
        test_simultaneous();
        test_read_latency3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
